io_v2: RTL



---
 rtl/io_pkg.sv | 16 +
 rtl/io_port_v2.sv | 52 +++++
 rtl/io_v2.sv | 104 ++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared register offsets and helpers for the io_v2 port block
package io_pkg;

    localparam logic [1:0] OFS_PIN  = 2'd0;
    localparam logic [1:0] OFS_DIR  = 2'd1;
    localparam logic [1:0] OFS_IEN  = 2'd2;
    localparam logic [1:0] OFS_FLAG = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/io_port_v2.sv
// rtl/io_port_v2.sv - one GPIO port: OUT/DIR/IEN/FLAG, input synchroniser, edge detect, pin view
module io_port_v2
    import io_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_out,
    input  logic             wr_dir,
    input  logic             wr_ien,
    input  logic             wr_flag,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] pad,
    output logic [WIDTH-1:0] out_q,
    output logic [WIDTH-1:0] dir_q,
    output logic [WIDTH-1:0] ien_q,
    output logic [WIDTH-1:0] flag_q,
    output logic [WIDTH-1:0] pin
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;

    assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign clr  = wr_flag ? d : '0;
    assign pin  = (dir_q & out_q) | (~dir_q & sync_q[SYNC_STAGES-1]);

    // Flag set has priority over a simultaneous write-1-to-clear on the same bit
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
            out_q  <= '0;
            dir_q  <= '0;
            ien_q  <= '0;
            flag_q <= '0;
        end else begin
            sync_q[0] <= pad;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
            if (wr_out) out_q <= d;
            if (wr_dir) dir_q <= d;
            if (wr_ien) ien_q <= d;
            flag_q <= (flag_q & ~clr) | (rise & ien_q);
        end
    end

endmodule

// File: rtl/io_v2.sv
// rtl/io_v2.sv - NPORT x WIDTH GPIO register block with two read channels and edge interrupts
module io_v2
    import io_pkg::*;
#(
    parameter  int WIDTH       = 8,
    parameter  int NPORT       = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int ADDR_W      = clog2(NPORT) + 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we,
    input  logic [ADDR_W-1:0]      addr,
    input  logic [WIDTH-1:0]       d,
    input  logic [ADDR_W-1:0]      cha,
    input  logic [ADDR_W-1:0]      chb,
    input  logic [NPORT*WIDTH-1:0] pad_in,
    output logic [NPORT*WIDTH-1:0] pad_out,
    output logic [NPORT*WIDTH-1:0] pad_oe,
    output logic [WIDTH-1:0]       da,
    output logic [WIDTH-1:0]       db,
    output logic                   irq
);

    localparam int NREG = 1 << ADDR_W;

    logic [WIDTH-1:0]  out_r  [NPORT];
    logic [WIDTH-1:0]  dir_r  [NPORT];
    logic [WIDTH-1:0]  ien_r  [NPORT];
    logic [WIDTH-1:0]  flag_r [NPORT];
    logic [WIDTH-1:0]  pin_r  [NPORT];
    logic [WIDTH-1:0]  regs   [NREG];
    logic [ADDR_W-1:0] wport;
    logic [1:0]        wofs;
    logic [ADDR_W-1:0] sel_a;
    logic [ADDR_W-1:0] sel_b;
    logic [WIDTH-1:0]  flag_any;

    assign wport = addr >> 2;
    assign wofs  = addr[1:0];

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic hit;
        assign hit = we && (wport == ADDR_W'(p));

        io_port_v2 #(
            .WIDTH       (WIDTH),
            .SYNC_STAGES (SYNC_STAGES)
        ) u_port (
            .clk     (clk),
            .rst     (rst),
            .wr_out  (hit && (wofs == OFS_PIN)),
            .wr_dir  (hit && (wofs == OFS_DIR)),
            .wr_ien  (hit && (wofs == OFS_IEN)),
            .wr_flag (hit && (wofs == OFS_FLAG)),
            .d       (d),
            .pad     (pad_in[p*WIDTH +: WIDTH]),
            .out_q   (out_r[p]),
            .dir_q   (dir_r[p]),
            .ien_q   (ien_r[p]),
            .flag_q  (flag_r[p]),
            .pin     (pin_r[p])
        );

        assign pad_out[p*WIDTH +: WIDTH] = out_r[p];
        assign pad_oe[p*WIDTH +: WIDTH]  = dir_r[p];
    end

    // Flat register view over the full address space; missing ports read as zero
    for (genvar r = 0; r < NREG; r++) begin : g_reg
        if (r / 4 >= NPORT) begin : g_none
            assign regs[r] = '0;
        end else if (r % 4 == 0) begin : g_pin
            assign regs[r] = pin_r[r/4];
        end else if (r % 4 == 1) begin : g_dir
            assign regs[r] = dir_r[r/4];
        end else if (r % 4 == 2) begin : g_ien
            assign regs[r] = ien_r[r/4];
        end else begin : g_flag
            assign regs[r] = flag_r[r/4];
        end
    end

    assign da = regs[sel_a];
    assign db = regs[sel_b];

    always_comb begin
        flag_any = '0;
        for (int p = 0; p < NPORT; p++) flag_any = flag_any | flag_r[p];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_a <= '0;
            sel_b <= '0;
            irq   <= 1'b0;
        end else begin
            sel_a <= cha;
            sel_b <= chb;
            irq   <= |flag_any;
        end
    end

endmodule
